phaethon_lsu: RTL

Parametrised multi-word load/store unit for the next-generation Phaethon core. It moves the RAM access phases (constant-address load/store, stack push/pop) out of the core's mode sequencer into a dedicated block. It accepts one command at a time, transfers 1..MAX_LEN words over the existing RAM req/ack handshake, and maintains the stack pointer internally. It adds bursts, an abort timeout and length checking, none of which the current core has.

---
 rtl/phaethon_lsu_if.sv | 51 +++++
 rtl/phaethon_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/phaethon_lsu_if.sv
// Command/response and RAM req/ack bundles for the Phaethon load/store unit.
// The core is master on the command bundle; the LSU is master on the RAM bundle.
interface phaethon_lsu_cmd_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic                      cmdValid;
  logic                      cmdReady;
  logic [1:0]                cmdOp;
  logic [ADDR_W-1:0]         cmdAddr;
  logic [LEN_W-1:0]          cmdLen;
  logic [MAX_LEN*DATA_W-1:0] cmdData;
  logic                      rspValid;
  logic                      rspErr;
  logic [MAX_LEN*DATA_W-1:0] rspData;

  modport master (
    output cmdValid, cmdOp, cmdAddr, cmdLen, cmdData,
    input  cmdReady, rspValid, rspErr, rspData
  );

  modport slave (
    input  cmdValid, cmdOp, cmdAddr, cmdLen, cmdData,
    output cmdReady, rspValid, rspErr, rspData
  );
endinterface

interface phaethon_lsu_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramOut;
  logic              readReq;
  logic              writeReq;
  logic [DATA_W-1:0] ramIn;
  logic              readAck;
  logic              writeAck;

  modport master (
    output ramAddress, ramOut, readReq, writeReq,
    input  ramIn, readAck, writeAck
  );

  modport slave (
    input  ramAddress, ramOut, readReq, writeReq,
    output ramIn, readAck, writeAck
  );
endinterface

// File: rtl/phaethon_lsu.sv
// Phaethon load/store unit: one LOAD/STORE/PUSH/POP of 1..MAX_LEN words over the RAM req/ack bus.
// Define LSU_TIMEOUT_EN to add the per-word WAIT timeout abort.
module phaethon_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_LEN = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  phaethon_lsu_cmd_if.slave  cmd,
  phaethon_lsu_ram_if.master ram,
  input  logic               spWe,
  input  logic [ADDR_W-1:0]  spIn,
  output logic [ADDR_W-1:0]  spOut
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int B     = DATA_W / 8;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  if (TIMEOUT < 1 || (DATA_W % 8) != 0) begin : gParamCheck
    $error("phaethon_lsu: TIMEOUT must be >= 1 and DATA_W a multiple of 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} stateT;

  stateT                     stateReg;
  stateT                     stateNext;
  logic [1:0]                opReg;
  logic [LEN_W-1:0]          lenReg;
  logic [LEN_W-1:0]          idxReg;
  logic [ADDR_W-1:0]         baseReg;
  logic [ADDR_W-1:0]         spReg;
  logic [MAX_LEN*DATA_W-1:0] dataReg;
  logic [MAX_LEN*DATA_W-1:0] rspDataReg;
  logic                      rspErrReg;

  logic              isRead;
  logic              lenBad;
  logic              ackHit;
  logic              lastWord;
  logic              timeoutHit;
  logic [ADDR_W-1:0] wordAddr;
  logic [ADDR_W-1:0] spDelta;

  assign isRead   = (opReg == OP_LOAD) || (opReg == OP_POP);
  assign lenBad   = (cmd.cmdLen == '0) || (cmd.cmdLen > LEN_W'(MAX_LEN));
  assign ackHit   = isRead ? ram.readAck : ram.writeAck;
  assign lastWord = (idxReg == lenReg - LEN_W'(1));
  assign spDelta  = ADDR_W'(lenReg) * ADDR_W'(B);

`ifdef LSU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] waitCntReg;

  // Counts completed WAIT cycles of the current word; restarts on every WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCntReg <= '0;
    end else if (stateReg != S_WAIT) begin
      waitCntReg <= '0;
    end else begin
      waitCntReg <= waitCntReg + TO_W'(1);
    end
  end

  assign timeoutHit = (stateReg == S_WAIT) && (waitCntReg == TO_W'(TIMEOUT - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // POP walks upward from the lowest word so lane 0 holds the oldest pushed entry.
  always_comb begin
    wordAddr = baseReg + ADDR_W'(idxReg) * ADDR_W'(B);
    case (opReg)
      OP_PUSH: wordAddr = spReg + ADDR_W'(idxReg) * ADDR_W'(B);
      OP_POP:  wordAddr = spReg - ADDR_W'(lenReg - idxReg) * ADDR_W'(B);
      default: wordAddr = baseReg + ADDR_W'(idxReg) * ADDR_W'(B);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_IDLE: begin
        if (cmd.cmdValid && !spWe) begin
          stateNext = lenBad ? S_RESP : S_REQ;
        end
      end
      S_REQ:  stateNext = S_WAIT;
      S_WAIT: begin
        if (ackHit) begin
          stateNext = lastWord ? S_RESP : S_REQ;
        end else if (timeoutHit) begin
          stateNext = S_RESP;
        end
      end
      S_RESP: stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    ram.ramAddress = '0;
    ram.ramOut     = '0;
    ram.readReq    = 1'b0;
    ram.writeReq   = 1'b0;
    if (stateReg == S_REQ) begin
      ram.ramAddress = wordAddr;
      if (isRead) begin
        ram.readReq = 1'b1;
      end else begin
        ram.writeReq = 1'b1;
        ram.ramOut   = dataReg[idxReg*DATA_W +: DATA_W];
      end
    end
  end

  assign cmd.cmdReady = (stateReg == S_IDLE) && !spWe && !reset;
  assign cmd.rspValid = (stateReg == S_RESP);
  assign cmd.rspErr   = rspErrReg;
  assign cmd.rspData  = rspDataReg;
  assign spOut        = spReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg      <= OP_LOAD;
      lenReg     <= '0;
      idxReg     <= '0;
      baseReg    <= '0;
      spReg      <= '0;
      dataReg    <= '0;
      rspDataReg <= '0;
      rspErrReg  <= 1'b0;
    end else begin
      case (stateReg)
        S_IDLE: begin
          if (spWe) begin
            spReg <= spIn;
          end else if (cmd.cmdValid) begin
            opReg      <= cmd.cmdOp;
            lenReg     <= cmd.cmdLen;
            baseReg    <= cmd.cmdAddr;
            dataReg    <= cmd.cmdData;
            rspDataReg <= '0;
            idxReg     <= '0;
            rspErrReg  <= lenBad;
          end
        end
        S_WAIT: begin
          if (ackHit) begin
            if (isRead) begin
              rspDataReg[idxReg*DATA_W +: DATA_W] <= ram.ramIn;
            end
            if (!lastWord) begin
              idxReg <= idxReg + LEN_W'(1);
            end
          end else if (timeoutHit) begin
            rspErrReg <= 1'b1;
          end
        end
        S_RESP: begin
          if (!rspErrReg) begin
            if (opReg == OP_PUSH) begin
              spReg <= spReg + spDelta;
            end else if (opReg == OP_POP) begin
              spReg <= spReg - spDelta;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
